// File: rtl/gaussian_window_ctrl_if.sv
// Pixel-in / window-out stream bundle between the pixel source, the window
// sequencer and the gaussian_operator stage.
interface gaussian_window_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_WIDTH-1:0]   pixel_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [9*DATA_WIDTH-1:0] kernel;
    logic                    frame_done;
    logic                    busy;

    modport master (
        output in_valid, pixel_in, out_ready,
        input  in_ready, out_valid, kernel, frame_done, busy
    );

    modport slave (
        input  in_valid, pixel_in, out_ready,
        output in_ready, out_valid, kernel, frame_done, busy
    );
endinterface

// File: rtl/gaussian_window_ctrl.sv
// 3x3 window sequencer: two line buffers plus a shifting register window,
// emitting one fully-interior window per accepted pixel and framing the stream.
//
// state | meaning
// FILL  | rows 0-1 arriving, only line buffers are being primed
// RUN   | rows 2..last arriving, interior pixels emit windows
// DONE  | whole frame accepted, input stalled until the last window drains
module gaussian_window_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                 clk,
    input  logic                 rst,
    gaussian_window_ctrl_if.slave bus
);
    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [DATA_WIDTH-1:0] line1 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line2 [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] win      [9];
    logic [DATA_WIDTH-1:0] win_next [9];

    logic                    out_valid_q;
    logic [9*DATA_WIDTH-1:0] kernel_q;
    logic                    frame_done_q;
    logic                    ready_int;
    logic                    accept;
    logic                    emit;
    logic                    done_fire;

    assign accept    = bus.in_valid && ready_int;
    assign emit      = accept && (col >= COL_W'(2)) && (row >= ROW_W'(2));
    assign done_fire = (state == DONE) && out_valid_q && bus.out_ready;

    assign bus.in_ready   = ready_int;
    assign bus.out_valid  = out_valid_q;
    assign bus.kernel     = kernel_q;
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state != FILL) || (col != '0) || (row != '0);

    // Window after this cycle's shift; the new right column comes from the line buffers.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_next[r*3]     = win[r*3 + 1];
            win_next[r*3 + 1] = win[r*3 + 2];
        end
        win_next[2] = line2[col];
        win_next[5] = line1[col];
        win_next[8] = bus.pixel_in;
    end

    always_comb begin
        state_next = state;
        ready_int  = 1'b0;
        case (state)
            FILL: begin
                ready_int = ~rst && (~out_valid_q || bus.out_ready);
                if (accept && row == ROW_W'(1) && col == COL_LAST)
                    state_next = RUN;
            end
            RUN: begin
                ready_int = ~rst && (~out_valid_q || bus.out_ready);
                if (accept && row == ROW_LAST && col == COL_LAST)
                    state_next = DONE;
            end
            DONE: begin
                if (done_fire)
                    state_next = FILL;
            end
            default: state_next = FILL;
        endcase
    end

    // Data path storage carries no reset; fill rows overwrite it before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            line2[col] <= line1[col];
            line1[col] <= bus.pixel_in;
            for (int i = 0; i < 9; i++)
                win[i] <= win_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FILL;
            col          <= '0;
            row          <= '0;
            out_valid_q  <= 1'b0;
            kernel_q     <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_next;
            frame_done_q <= done_fire;

            if (done_fire) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    col <= col + COL_W'(1);
                end
            end

            if (emit) begin
                out_valid_q <= 1'b1;
                for (int i = 0; i < 9; i++)
                    kernel_q[i*DATA_WIDTH +: DATA_WIDTH] <= win_next[i];
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Bench for gaussian_window_ctrl on a 5x4 image: reference table for the ramp
// frame, scoreboard of windows computed from the stored image for every frame.
module tb_gaussian_window_ctrl;
    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int KW = 9 * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gaussian_window_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    gaussian_window_ctrl #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int            trig_pix;
        logic [KW-1:0] kern;
    } vec_t;

    typedef struct {
        int            pix;
        logic [KW-1:0] k;
    } obs_t;

    vec_t          tbl [6];
    obs_t          obs_q [$];
    logic [KW-1:0] exp_q [$];
    logic [DW-1:0] img [H][W];

    int            checks = 0;
    int            errors = 0;
    int            tcol = 0, trow = 0, acc_cnt = 0, last_idx = -1, cur_pix = -1;
    int            win_cnt = 0, frames_done = 0;
    bit            frame_in_done = 0, seen_cur = 0, held_valid = 0, prev_fd = 0;
    logic [KW-1:0] held_k;

    task automatic chk_i(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic chk_k(input string name, input logic [KW-1:0] act, input logic [KW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [KW-1:0] pack9(input int e[9]);
        logic [KW-1:0] k = '0;
        for (int i = 0; i < 9; i++) k[i*DW +: DW] = 8'(e[i]);
        return k;
    endfunction

    function automatic vec_t mk(input int t, input int e[9]);
        vec_t v;
        v.trig_pix = t;
        v.kern     = pack9(e);
        return v;
    endfunction

    // Window whose bottom-right pixel is (c, r), taken straight from the image.
    function automatic logic [KW-1:0] model_win(input int c, input int r);
        logic [KW-1:0] k = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                k[(rr*3 + cc)*DW +: DW] = img[r-2+rr][c-2+cc];
        return k;
    endfunction

    // One clock: observe at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (held_valid) begin
                chk_i("valid_hold", int'(bus.out_valid), 1);
                chk_k("kernel_hold", bus.kernel, held_k);
            end
            if (bus.out_valid && !seen_cur) begin
                cur_pix  = last_idx;
                seen_cur = 1;
            end
            if (bus.out_valid && bus.out_ready) begin
                obs_q.push_back('{cur_pix, bus.kernel});
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window_extra: got %h expected no window", bus.kernel);
                end else begin
                    chk_k("window_sb", bus.kernel, exp_q.pop_front());
                end
                win_cnt++;
                seen_cur   = 0;
                held_valid = 0;
            end else begin
                held_valid = bus.out_valid;
                held_k     = bus.kernel;
            end
            if (bus.frame_done) begin
                chk_i("fd_in_ready", int'(bus.in_ready), 1);
                chk_i("fd_single", int'(prev_fd), 0);
                frames_done++;
                frame_in_done = 0;
            end else if (frame_in_done) begin
                chk_i("done_stall", int'(bus.in_ready), 0);
            end
            prev_fd = bus.frame_done;
            if (bus.in_valid && bus.in_ready) begin
                if (tcol >= 2 && trow >= 2) exp_q.push_back(model_win(tcol, trow));
                last_idx = trow * W + tcol;
                acc_cnt++;
                if (tcol == W - 1) begin
                    tcol = 0;
                    if (trow == H - 1) begin
                        trow          = 0;
                        frame_in_done = 1;
                    end else begin
                        trow++;
                    end
                end else begin
                    tcol++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int vpct, input int rpct);
        bus.in_valid  = !frame_in_done && (int'($urandom_range(99)) < vpct);
        bus.pixel_in  = img[trow][tcol];
        bus.out_ready = int'($urandom_range(99)) < rpct;
        tick();
    endtask

    task automatic begin_frame(input bit ramp);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                img[y][x] = ramp ? 8'(y*W + x) : 8'($urandom);
        obs_q.delete();
        win_cnt = 0;
        acc_cnt = 0;
    endtask

    task automatic run_frame(input int vpct, input int rpct);
        int start = frames_done;
        int n = 0;
        while (frames_done == start && n < 2000) begin
            drive(vpct, rpct);
            n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (frames_done == start) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got no frame_done expected one within %0d cycles", n);
        end
        chk_i("frame_windows", win_cnt, 6);
        chk_i("sb_empty", exp_q.size(), 0);
    endtask

    task automatic check_table(input bit lat);
        chk_i("n_windows", obs_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < obs_q.size()) begin
                chk_k($sformatf("tbl_win%0d", i), obs_q[i].k, tbl[i].kern);
                if (lat) chk_i($sformatf("tbl_lat%0d", i), obs_q[i].pix, tbl[i].trig_pix);
            end
        end
    endtask

    initial begin
        int n;
        tbl[0] = mk(12, '{0, 1, 2, 5, 6, 7, 10, 11, 12});
        tbl[1] = mk(13, '{1, 2, 3, 6, 7, 8, 11, 12, 13});
        tbl[2] = mk(14, '{2, 3, 4, 7, 8, 9, 12, 13, 14});
        tbl[3] = mk(17, '{5, 6, 7, 10, 11, 12, 15, 16, 17});
        tbl[4] = mk(18, '{6, 7, 8, 11, 12, 13, 16, 17, 18});
        tbl[5] = mk(19, '{7, 8, 9, 12, 13, 14, 17, 18, 19});

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.pixel_in  = '0;
        bus.out_ready = 1'b1;
        begin_frame(1);
        repeat (3) tick();
        chk_i("rst_out_valid", int'(bus.out_valid), 0);
        chk_k("rst_kernel", bus.kernel, '0);
        chk_i("rst_frame_done", int'(bus.frame_done), 0);
        chk_i("rst_busy", int'(bus.busy), 0);
        chk_i("rst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        #1;
        chk_i("post_rst_in_ready", int'(bus.in_ready), 1);

        // Two identical ramp frames, continuous stream.
        for (int f = 0; f < 2; f++) begin
            begin_frame(1);
            run_frame(100, 100);
            check_table(1);
            chk_i("idle_busy", int'(bus.busy), 0);
        end

        // Backpressure right after the first window.
        begin_frame(1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            drive(100, 100);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.pixel_in  = img[trow][tcol];
            #1;
            chk_i("bp_in_ready", int'(bus.in_ready), 0);
            chk_k("bp_kernel", bus.kernel, tbl[0].kern);
            tick();
        end
        run_frame(100, 100);
        check_table(0);

        // Upstream gaps.
        begin_frame(1);
        run_frame(60, 100);
        check_table(0);

        // Reset after pixel 13, then a fresh frame.
        begin_frame(1);
        n = 0;
        while (acc_cnt < 14 && n < 100) begin
            drive(100, 100);
            n++;
        end
        bus.in_valid = 1'b0;
        chk_i("mid_busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        chk_i("mrst_out_valid", int'(bus.out_valid), 0);
        chk_k("mrst_kernel", bus.kernel, '0);
        chk_i("mrst_busy", int'(bus.busy), 0);
        chk_i("mrst_in_ready", int'(bus.in_ready), 0);
        rst = 1'b0;
        tcol = 0; trow = 0; last_idx = -1;
        exp_q.delete();
        held_valid = 0; seen_cur = 0; frame_in_done = 0; prev_fd = 0;
        #1;
        chk_i("mrst_in_ready_after", int'(bus.in_ready), 1);
        begin_frame(1);
        run_frame(100, 100);
        check_table(1);

        // Random images, random gaps and random backpressure.
        for (int f = 0; f < 50; f++) begin
            begin_frame(0);
            run_frame(70, 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
